// File: rtl/bcd_to_bin_pkg.sv
// bcd_to_bin_pkg: shared constants, state encoding and digit helper for the BCD converters.
`default_nettype none

package bcd_to_bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int         BCD_ITER       = 9;
  localparam int         BCD_MAX_DIGIT  = 9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;
  localparam logic [3:0] BCD_LAST_CNT   = 4'(BCD_ITER - 1);

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > 4'(BCD_MAX_DIGIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_nibble_adj.sv
// bcd_nibble_adj: reverse double-dabble correction, subtracts 3 from a nibble that is 8 or more.
`default_nettype none

module bcd_nibble_adj
  import bcd_to_bin_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= BCD_ADJ_THRESH) ? (nib_i - BCD_ADJ_SUB) : nib_i;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential three-digit BCD to 8-bit binary converter (reverse double-dabble,
// one bit per clock, fixed 10-cycle latency from capture to the done pulse).
`default_nettype none

module bcd_to_bin
  import bcd_to_bin_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic [7:0] bin,
  output logic       ovf,
  output logic       err,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [9:0] bcd_q,   bcd_d;
  logic [8:0] sr_q,    sr_d;
  logic       inv_q,   inv_d;
  logic [7:0] bin_q,   bin_d;
  logic       ovf_q,   ovf_d;
  logic       err_q,   err_d;

  logic [9:0] bcd_sh;
  logic [8:0] bin_sh;
  logic [3:0] tens_adj;
  logic [3:0] units_adj;

  // The {BCD,binary} pair shifted right by one: BCD LSB falls into the binary MSB.
  assign bcd_sh = {1'b0, bcd_q[9:1]};
  assign bin_sh = {bcd_q[0], sr_q[8:1]};

  bcd_nibble_adj u_adj_tens (
    .nib_i (bcd_sh[7:4]),
    .nib_o (tens_adj)
  );

  bcd_nibble_adj u_adj_units (
    .nib_i (bcd_sh[3:0]),
    .nib_o (units_adj)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      bcd_q   <= 10'd0;
      sr_q    <= 9'd0;
      inv_q   <= 1'b0;
      bin_q   <= 8'h00;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      sr_q    <= sr_d;
      inv_q   <= inv_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sr_d    = sr_q;
    inv_d   = inv_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    unique case (state_q)
      // The DONE cycle is also the first point a new request can be sampled, so a
      // continuously held start yields one conversion every 10 cycles.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          bcd_d   = {bcd2, bcd1, bcd0};
          sr_d    = 9'd0;
          cnt_d   = 4'd0;
          inv_d   = digit_invalid(bcd1) | digit_invalid(bcd0);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_sh[9:8], tens_adj, units_adj};
        sr_d  = bin_sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == BCD_LAST_CNT) begin
          state_d = ST_DONE;
          if (inv_q) begin
            bin_d = 8'h00;
            ovf_d = 1'b0;
            err_d = 1'b1;
          end else begin
            bin_d = bin_sh[7:0];
            ovf_d = bin_sh[8];
            err_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bin  = bin_q;
  assign ovf  = ovf_q;
  assign err  = err_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: table-driven vectors with a scoreboard queue checked on each done pulse.
`default_nettype none

module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic [7:0] bin;
  logic       ovf;
  logic       err;
  logic       busy;
  logic       done;

  typedef struct {
    logic [1:0] b2;
    logic [3:0] b1;
    logic [3:0] b0;
    logic [7:0] bin;
    logic       ovf;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic [7:0] bin;
    logic       ovf;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  vec_t tbl[8];
  int   n_checks = 0;
  int   n_err    = 0;

  bcd_to_bin dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd2  (bcd2),
    .bcd1  (bcd1),
    .bcd0  (bcd0),
    .bin   (bin),
    .ovf   (ovf),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bin", {24'd0, bin}, {24'd0, e.bin});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        chk("err", {31'd0, err}, {31'd0, e.err});
        last_exp = e;
      end
    end
  end

  task automatic scramble();
    bcd2 = 2'($urandom);
    bcd1 = 4'($urandom);
    bcd0 = 4'($urandom);
  endtask

  // One conversion: drive at a falling edge, then walk the 9 busy cycles and the done cycle.
  task automatic do_conv(input vec_t v);
    @(negedge clk);
    bcd2  = v.b2;
    bcd1  = v.b1;
    bcd0  = v.b0;
    start = 1'b1;
    sb.push_back('{bin: v.bin, ovf: v.ovf, err: v.err});
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    for (int i = 0; i < 9; i++) begin
      chk("busy", {31'd0, busy}, 32'd1);
      chk("done_early", {31'd0, done}, 32'd0);
      if (i == 4) begin
        chk("hold_bin", {24'd0, bin}, {24'd0, last_exp.bin});
        chk("hold_ovf", {31'd0, ovf}, {31'd0, last_exp.ovf});
        chk("hold_err", {31'd0, err}, {31'd0, last_exp.err});
      end
      @(posedge clk);
      #1;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n_done;
    rst      = 1'b1;
    start    = 1'b0;
    bcd2     = 2'd0;
    bcd1     = 4'd0;
    bcd0     = 4'd0;
    last_exp = '0;

    tbl[0] = '{2'd2, 4'd5,  4'd5,  8'hFF, 1'b0, 1'b0};
    tbl[1] = '{2'd0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0};
    tbl[2] = '{2'd1, 4'd2,  4'd8,  8'h80, 1'b0, 1'b0};
    tbl[3] = '{2'd2, 4'd5,  4'd6,  8'h00, 1'b1, 1'b0};
    tbl[4] = '{2'd3, 4'd9,  4'd9,  8'h8F, 1'b1, 1'b0};
    tbl[5] = '{2'd1, 4'hA,  4'd3,  8'h00, 1'b0, 1'b1};
    tbl[6] = '{2'd0, 4'd4,  4'd2,  8'h2A, 1'b0, 1'b0};
    tbl[7] = '{2'd0, 4'd3,  4'hF,  8'h00, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bin",  {24'd0, bin},  32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);

    for (int i = 0; i < 8; i++) do_conv(tbl[i]);

    // start held high: A captured at edge k, B presented mid-shift and captured at k+10.
    @(negedge clk);
    bcd2 = 2'd3; bcd1 = 4'd9; bcd0 = 4'd9;
    start = 1'b1;
    sb.push_back('{bin: 8'h8F, ovf: 1'b1, err: 1'b0});
    @(posedge clk);
    #1;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk);
      #1;
      if (c == 1 || c == 10) scramble();
      if (c == 5) begin
        bcd2 = 2'd1; bcd1 = 4'd5; bcd0 = 4'd0;
        sb.push_back('{bin: 8'h96, ovf: 1'b0, err: 1'b0});
      end
      if (c == 9) begin
        chk("cont_done_a", {31'd0, done}, 32'd1);
        chk("cont_busy_a", {31'd0, busy}, 32'd0);
      end
      if (c == 10) begin
        chk("cont_accept_b", {31'd0, busy}, 32'd1);
        start = 1'b0;
      end
      if (c == 19) chk("cont_done_b", {31'd0, done}, 32'd1);
    end
    @(posedge clk);
    #1;
    chk("cont_idle", {31'd0, busy}, 32'd0);

    // Reset at the 5th shift edge of 2,0,0 aborts without a done pulse.
    @(negedge clk);
    bcd2 = 2'd2; bcd1 = 4'd0; bcd0 = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_exp = '0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bin",  {24'd0, bin},  32'd0);
    chk("abort_ovf",  {31'd0, ovf},  32'd0);
    chk("abort_err",  {31'd0, err},  32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    chk("abort_no_done", n_done, 32'd0);

    // rst and start on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("rst_beats_start", {31'd0, busy}, 32'd0);

    do_conv('{2'd0, 4'd9, 4'd9, 8'h63, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
